// File: rtl/zmips_pkg.sv
// Shared ZMIPS definitions.
//   dbus_state_t : data-bus controller FSM states
//   WORD_BYTES   : bytes per data word
//   DMEM_ADDR_W  : default data-SRAM word-address width
//   LAT_CNT_W    : width of the read-latency down-counter (RD_LAT up to 4)
package zmips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RREQ  = 2'd1,
    RWAIT = 2'd2,
    RDONE = 2'd3
  } dbus_state_t;

  localparam int WORD_BYTES  = 4;
  localparam int DMEM_ADDR_W = 12;
  localparam int LAT_CNT_W   = 2;

endpackage

// File: rtl/zmips_wbuf.sv
// One-entry posted-write buffer for the data bus controller.
//   load/ld_addr/ld_data : capture a new store (wins over a same-cycle drain)
//   drain                : the buffered store is being written to SRAM this cycle
//   lookup_addr/hit      : combinational match of a load word address
//   valid/addr/data      : current buffer contents
module zmips_wbuf #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              drain,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       data,
  output logic              hit
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else begin
      // A store arriving in the drain cycle refills the entry, so
      // back-to-back stores never need to wait.
      if (load) begin
        valid <= 1'b1;
        addr  <= ld_addr;
        data  <= ld_data;
      end else if (drain) begin
        valid <= 1'b0;
      end
    end
  end

  assign hit = valid && (addr == lookup_addr);

endmodule

// File: rtl/zmips_dbus_ctrl.sv
// ZMIPS data-bus controller: core data port to single-port synchronous SRAM.
//   cpu_addr/cpu_wdata/cpu_wr/cpu_rd : core request (level, held while stalled)
//   cpu_rdata/cpu_stall/cpu_fault    : load data, combinational stall, reject pulse
//   mem_addr/mem_wdata/mem_we/mem_re : registered SRAM controls
//   mem_rdata                        : SRAM data, valid RD_LAT cycles after mem_re
//   dbg_state                        : current FSM state for observation
// Handshake: a request is taken in any cycle where cpu_wr or cpu_rd is high and
// cpu_stall is low; while cpu_stall is high the core holds its request unchanged.
module zmips_dbus_ctrl
  import zmips_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              cpu_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output dbus_state_t       dbg_state
);

  localparam int BYTE_OFF_W = $clog2(WORD_BYTES);

  dbus_state_t          state, state_d;
  logic [LAT_CNT_W-1:0] lat_cnt;
  logic [31:0]          rd_q;

  logic [ADDR_W-1:0] req_waddr;
  logic              addr_fault;
  logic              fault_c;
  logic              wr_ok, rd_ok, rd_hit, rd_miss;
  logic              stall_c, fault_o;
  logic [31:0]       rdata_c;

  logic              wb_valid, wb_hit;
  logic [ADDR_W-1:0] wb_addr;
  logic [31:0]       wb_data;

  assign req_waddr  = cpu_addr[ADDR_W+BYTE_OFF_W-1:BYTE_OFF_W];
  assign addr_fault = (cpu_addr[BYTE_OFF_W-1:0] != '0) ||
                      ((cpu_addr >> (ADDR_W + BYTE_OFF_W)) != 32'd0);

  // Requests are only looked at in IDLE.
  assign fault_c = (state == IDLE) && (cpu_wr || cpu_rd) &&
                   (addr_fault || (cpu_wr && cpu_rd));
  assign wr_ok   = (state == IDLE) && cpu_wr && !fault_c;
  assign rd_ok   = (state == IDLE) && cpu_rd && !fault_c;
  assign rd_hit  = rd_ok && wb_hit;
  assign rd_miss = rd_ok && !wb_hit;

  zmips_wbuf #(.ADDR_W(ADDR_W)) u_wbuf (
    .clk         (clk),
    .rst         (rst),
    .load        (wr_ok),
    .ld_addr     (req_waddr),
    .ld_data     (cpu_wdata),
    .drain       (mem_we),
    .lookup_addr (req_waddr),
    .valid       (wb_valid),
    .addr        (wb_addr),
    .data        (wb_data),
    .hit         (wb_hit)
  );

  always_comb begin
    state_d = state;
    stall_c = 1'b0;
    fault_o = 1'b0;
    rdata_c = '0;
    case (state)
      IDLE: begin
        fault_o = fault_c;
        if (rd_hit) rdata_c = wb_data;
        if (rd_miss) begin
          stall_c = 1'b1;
          state_d = RREQ;
        end
      end
      RREQ: begin
        stall_c = 1'b1;
        state_d = RWAIT;
      end
      RWAIT: begin
        stall_c = 1'b1;
        if (lat_cnt == '0) state_d = RDONE;
      end
      RDONE: begin
        rdata_c = rd_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      rd_q      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
    end else begin
      state <= state_d;
      // The store strobe follows the buffer load by one cycle, which is the
      // drain cycle; the buffer still holds the entry then for forwarding.
      // Stores and loads are mutually exclusive (both is a fault), so the two
      // strobes can never be registered high together.
      mem_we <= wr_ok;
      mem_re <= rd_miss;
      if (wr_ok) begin
        mem_addr  <= req_waddr;
        mem_wdata <= cpu_wdata;
      end else if (rd_miss) begin
        mem_addr <= req_waddr;
      end
      if (state == RREQ) begin
        lat_cnt <= LAT_CNT_W'(RD_LAT - 1);
      end else if (state == RWAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (state == RWAIT && lat_cnt == '0) rd_q <= mem_rdata;
    end
  end

  // Reset forces the combinational outputs quiet regardless of inputs.
  assign cpu_stall = rst && stall_c;
  assign cpu_fault = rst && fault_o;
  assign cpu_rdata = rst ? rdata_c : 32'd0;
  assign dbg_state = state;

endmodule

// File: tb/tb_zmips_dbus_ctrl.sv
module tb_zmips_dbus_ctrl;
  import zmips_pkg::*;

  localparam int ADDR_W = 12;
  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]       cpu_addr = '0;
  logic [31:0]       cpu_wdata = '0;
  logic              cpu_wr = 1'b0;
  logic              cpu_rd = 1'b0;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              cpu_fault;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  dbus_state_t       dbg_state;

  zmips_dbus_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .cpu_fault (cpu_fault),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- SRAM read-latency model ----------------
  logic [31:0] sram_val = 32'h0;
  logic [3:0]  re_pipe = '0;
  always @(posedge clk) re_pipe <= {re_pipe[2:0], mem_re};
  assign mem_rdata = re_pipe[RD_LAT-1] ? sram_val : 32'hBAD0BAD0;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int errors = 0;
  int checks = 0;
  int re_count = 0;
  logic [31:0] re_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Every SRAM write is matched against the stores in issue order.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_re) begin
        re_count++;
        re_addr = 32'(mem_addr);
      end
      if (mem_we) begin
        chk("we_re_excl", 32'(mem_re), 32'd0);
        if (wr_addr_q.size() == 0) chk("unexpected_we", 32'(mem_we), 32'd0);
        else begin
          chk("we_addr", 32'(mem_addr), wr_addr_q.pop_front());
          chk("we_data", mem_wdata, wr_data_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    cpu_addr  = addr;
    cpu_wdata = data;
    cpu_wr    = 1'b1;
    cpu_rd    = 1'b0;
    wr_addr_q.push_back(addr >> 2);
    wr_data_q.push_back(data);
    @(negedge clk);
    chk("store_nostall", 32'(cpu_stall), 32'd0);
    chk("store_nofault", 32'(cpu_fault), 32'd0);
    next_cycle();
    cpu_wr = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] exp, output int stalls);
    stalls = 0;
    exp_q.push_back(exp);
    cpu_addr = addr;
    cpu_rd   = 1'b1;
    cpu_wr   = 1'b0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) begin
        chk("load_data", cpu_rdata, exp_q.pop_front());
        break;
      end
      stalls++;
      if (stalls > 20) begin
        chk("load_timeout", 32'(cpu_stall), 32'd0);
        void'(exp_q.pop_front());
        break;
      end
    end
    next_cycle();
    cpu_rd = 1'b0;
  endtask

  task automatic do_fault(input logic wr, input logic rd, input logic [31:0] addr);
    cpu_addr  = addr;
    cpu_wdata = 32'h5A5A5A5A;
    cpu_wr    = wr;
    cpu_rd    = rd;
    @(negedge clk);
    chk("fault_pulse", 32'(cpu_fault), 32'd1);
    chk("fault_nostall", 32'(cpu_stall), 32'd0);
    chk("fault_rdata", cpu_rdata, 32'd0);
    next_cycle();
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    #1;
    chk("fault_one_cycle", 32'(cpu_fault), 32'd0);
    chk("fault_no_we", 32'(mem_we), 32'd0);
    chk("fault_no_re", 32'(mem_re), 32'd0);
    chk("fault_state", 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int stalls;
    int re_before;

    // Reset values, with a would-be miss held on the bus.
    cpu_addr = 32'h40;
    cpu_rd   = 1'b1;
    #12;
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_fault", 32'(cpu_fault), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    cpu_rd = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    next_cycle();

    // Posted store: strobe one cycle later.
    do_store(32'h10, 32'hDEADBEEF);
    chk("t1_we", 32'(mem_we), 32'd1);
    chk("t1_addr", 32'(mem_addr), 32'd4);
    chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
    next_cycle();

    // Load hitting the buffered store in its drain cycle.
    do_store(32'h20, 32'h11);
    do_load(32'h20, 32'h11, stalls);
    chk("t2_hit_nostall", 32'(stalls), 32'd0);
    next_cycle();

    // Load miss through the SRAM.
    sram_val  = 32'hCAFEF00D;
    re_before = re_count;
    do_load(32'h40, 32'hCAFEF00D, stalls);
    chk("t3_stall_cycles", 32'(stalls), 32'(RD_LAT + 2));
    chk("t3_re_pulses", 32'(re_count - re_before), 32'd1);
    chk("t3_re_addr", re_addr, 32'h10);
    next_cycle();

    // Back-to-back stores.
    do_store(32'h0, 32'h100);
    chk("t4_we0", 32'(mem_we), 32'd1);
    chk("t4_addr0", 32'(mem_addr), 32'd0);
    do_store(32'h4, 32'h101);
    chk("t4_we1", 32'(mem_we), 32'd1);
    chk("t4_addr1", 32'(mem_addr), 32'd1);
    do_store(32'h8, 32'h102);
    chk("t4_we2", 32'(mem_we), 32'd1);
    chk("t4_addr2", 32'(mem_addr), 32'd2);
    next_cycle();
    chk("t4_we_end", 32'(mem_we), 32'd0);

    // Rejected accesses.
    do_fault(1'b1, 1'b0, 32'h6);
    do_fault(1'b0, 1'b1, 32'h0001_0000);
    do_fault(1'b1, 1'b1, 32'h24);
    next_cycle();

    // Reset during RWAIT aborts the read.
    sram_val = 32'h12345678;
    cpu_addr = 32'h80;
    cpu_rd   = 1'b1;
    next_cycle();
    chk("t6_rreq", 32'(dbg_state), 32'(RREQ));
    chk("t6_re", 32'(mem_re), 32'd1);
    next_cycle();
    chk("t6_rwait", 32'(dbg_state), 32'(RWAIT));
    rst = 1'b0;
    #1;
    chk("t6_rst_stall", 32'(cpu_stall), 32'd0);
    chk("t6_rst_re", 32'(mem_re), 32'd0);
    chk("t6_rst_state", 32'(dbg_state), 32'(IDLE));
    chk("t6_rst_rdata", cpu_rdata, 32'd0);
    cpu_rd = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    next_cycle();

    // Reset during a drain discards the buffered store.
    do_store(32'h200, 32'h5555AAAA);
    chk("t6_drain_we", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_drain_abort", 32'(mem_we), 32'd0);
    void'(wr_addr_q.pop_back());
    void'(wr_data_q.pop_back());
    @(negedge clk);
    #1 rst = 1'b1;
    next_cycle();

    // Fresh load after reset: buffer is empty so it must go to SRAM.
    sram_val = 32'h0BADF00D;
    do_load(32'h200, 32'h0BADF00D, stalls);
    chk("t6_fresh_stalls", 32'(stalls), 32'(RD_LAT + 2));
    next_cycle();

    chk("wr_q_drained", 32'(wr_addr_q.size()), 32'd0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
